// File: rtl/hsv2rgb.sv
// hsv2rgb: three-stage pipelined HSV to RGB converter carrying pixel position tags.
// Optional macro HSV2RGB_PACK444_EN adds a registered 12-bit 4:4:4 packed output (rgb444).
module hsv2rgb (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  h,
   input  logic [7:0]  s,
   input  logic [7:0]  v,
   input  logic        hsv_valid,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        rgb_valid,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out
`ifdef HSV2RGB_PACK444_EN
   ,
   output logic [11:0] rgb444
`endif
);

   localparam int unsigned CW  = 8;
   localparam int unsigned PW  = 16;
   localparam int unsigned HCW = 11;
   localparam int unsigned VCW = 10;
   localparam int unsigned RW  = 3;

   localparam logic [CW-1:0] FULL = 8'd255;

   // stage 1 registers
   logic           vld1;
   logic [RW-1:0]  region1;
   logic [CW-1:0]  rem1;
   logic [CW-1:0]  s1;
   logic [CW-1:0]  v1;
   logic [HCW-1:0] hc1;
   logic [VCW-1:0] vc1;

   // stage 2 registers
   logic           vld2;
   logic [RW-1:0]  region2;
   logic           grey2;
   logic [CW-1:0]  p2;
   logic [CW-1:0]  q2;
   logic [CW-1:0]  t2;
   logic [CW-1:0]  v2;
   logic [HCW-1:0] hc2;
   logic [VCW-1:0] vc2;

   // stage 1 combinational: hue sector (h/43) and scaled offset within it
   logic [RW-1:0] region_c;
   logic [CW-1:0] base_c;
   logic [CW-1:0] diff_c;
   logic [CW-1:0] rem_c;

   // Hue sector by threshold compare instead of a divider; base is region*43.
   always_comb begin
      region_c = '0;
      base_c   = '0;
      if (h < 8'd43) begin
         region_c = 3'd0;
         base_c   = 8'd0;
      end else if (h < 8'd86) begin
         region_c = 3'd1;
         base_c   = 8'd43;
      end else if (h < 8'd129) begin
         region_c = 3'd2;
         base_c   = 8'd86;
      end else if (h < 8'd172) begin
         region_c = 3'd3;
         base_c   = 8'd129;
      end else if (h < 8'd215) begin
         region_c = 3'd4;
         base_c   = 8'd172;
      end else begin
         region_c = 3'd5;
         base_c   = 8'd215;
      end
      diff_c = h - base_c;
      rem_c  = CW'(PW'(diff_c) * 16'd6);
   end

   // Stage 1 valid; cleared by reset so in-flight pixels are dropped.
   always_ff @(posedge clock) begin
      if (reset) vld1 <= 1'b0;
      else       vld1 <= hsv_valid;
   end

   // Stage 1 data; free-running, qualified by vld1.
   always_ff @(posedge clock) begin
      region1 <= region_c;
      rem1    <= rem_c;
      s1      <= s;
      v1      <= v;
      hc1     <= hcount_in;
      vc1     <= vcount_in;
   end

   // stage 2 combinational: p/q/t via 16-bit products, each scaled back by >>8
   logic [PW-1:0] sr_c;
   logic [PW-1:0] srn_c;
   logic [CW-1:0] sr8_c;
   logic [CW-1:0] srn8_c;
   logic [PW-1:0] pp_c;
   logic [PW-1:0] qp_c;
   logic [PW-1:0] tp_c;

   // Products are at most 255*255, so nothing overflows 16 bits.
   always_comb begin
      sr_c   = PW'(s1) * PW'(rem1);
      srn_c  = PW'(s1) * PW'(FULL - rem1);
      sr8_c  = CW'(sr_c >> 8);
      srn8_c = CW'(srn_c >> 8);
      pp_c   = PW'(v1) * PW'(FULL - s1);
      qp_c   = PW'(v1) * PW'(FULL - sr8_c);
      tp_c   = PW'(v1) * PW'(FULL - srn8_c);
   end

   // Stage 2 valid.
   always_ff @(posedge clock) begin
      if (reset) vld2 <= 1'b0;
      else       vld2 <= vld1;
   end

   // Stage 2 data; free-running.
   always_ff @(posedge clock) begin
      p2      <= CW'(pp_c >> 8);
      q2      <= CW'(qp_c >> 8);
      t2      <= CW'(tp_c >> 8);
      v2      <= v1;
      region2 <= region1;
      grey2   <= (s1 == '0);
      hc2     <= hc1;
      vc2     <= vc1;
   end

   // stage 3 combinational: sector select, grey override when saturation is zero
   logic [CW-1:0] r_c;
   logic [CW-1:0] g_c;
   logic [CW-1:0] b_c;

   // Map (p,q,t,v) onto r/g/b by sector.
   always_comb begin
      r_c = v2;
      g_c = p2;
      b_c = q2;
      unique case (region2)
         3'd0:    begin r_c = v2; g_c = t2; b_c = p2; end
         3'd1:    begin r_c = q2; g_c = v2; b_c = p2; end
         3'd2:    begin r_c = p2; g_c = v2; b_c = t2; end
         3'd3:    begin r_c = p2; g_c = q2; b_c = v2; end
         3'd4:    begin r_c = t2; g_c = p2; b_c = v2; end
         default: begin r_c = v2; g_c = p2; b_c = q2; end
      endcase
      if (grey2) begin
         r_c = v2;
         g_c = v2;
         b_c = v2;
      end
   end

   // Output registers: load only on a valid pixel, otherwise hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         rgb_valid  <= 1'b0;
         r          <= '0;
         g          <= '0;
         b          <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
`ifdef HSV2RGB_PACK444_EN
         rgb444     <= 12'h000;
`endif
      end else begin
         rgb_valid <= vld2;
         if (vld2) begin
            r          <= r_c;
            g          <= g_c;
            b          <= b_c;
            hcount_out <= hc2;
            vcount_out <= vc2;
`ifdef HSV2RGB_PACK444_EN
            rgb444     <= {r_c[7:4], g_c[7:4], b_c[7:4]};
`endif
         end
      end
   end

endmodule

// File: tb/tb_hsv2rgb.sv
// tb_hsv2rgb: scoreboard bench for hsv2rgb (define HSV2RGB_PACK444_EN to also check rgb444).
module tb_hsv2rgb;

   typedef struct {
      int r;
      int g;
      int b;
      int hc;
      int vc;
   } px_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  h;
   logic [7:0]  s;
   logic [7:0]  v;
   logic        hsv_valid;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        rgb_valid;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
`ifdef HSV2RGB_PACK444_EN
   logic [11:0] rgb444;
`endif

   int  vectors = 0;
   int  errors  = 0;
   px_t sb[$];
   px_t exp_out;
   logic [2:0] exp_vpipe;
   logic       rst_q;
   logic       armed = 1'b0;

   hsv2rgb dut (
      .clock      (clock),
      .reset      (reset),
      .h          (h),
      .s          (s),
      .v          (v),
      .hsv_valid  (hsv_valid),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .r          (r),
      .g          (g),
      .b          (b),
      .rgb_valid  (rgb_valid),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out)
`ifdef HSV2RGB_PACK444_EN
      ,
      .rgb444     (rgb444)
`endif
   );

   always #5 clock = ~clock;

   // Count a comparison and report any difference.
   task automatic chk(input string tag, input int got, input int want);
      vectors++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference conversion built directly from the integer formulas.
   function automatic px_t ref_px(input int hh, input int ss, input int vv, input int hc, input int vc);
      px_t o;
      int reg_n, rem, p, q, t;
      reg_n = hh / 43;
      rem   = (hh - reg_n * 43) * 6;
      p = (vv * (255 - ss)) / 256;
      q = (vv * (255 - (ss * rem) / 256)) / 256;
      t = (vv * (255 - (ss * (255 - rem)) / 256)) / 256;
      case (reg_n)
         0:       begin o.r = vv; o.g = t;  o.b = p;  end
         1:       begin o.r = q;  o.g = vv; o.b = p;  end
         2:       begin o.r = p;  o.g = vv; o.b = t;  end
         3:       begin o.r = p;  o.g = q;  o.b = vv; end
         4:       begin o.r = t;  o.g = p;  o.b = vv; end
         default: begin o.r = vv; o.g = p;  o.b = q;  end
      endcase
      if (ss == 0) begin
         o.r = vv; o.g = vv; o.b = vv;
      end
      o.hc = hc;
      o.vc = vc;
      return o;
   endfunction

   // Drive one cycle of inputs; a valid, non-reset pixel pushes its expected result.
   task automatic drive(input logic rst, input logic vld, input int hh, input int ss, input int vv,
                        input int hc, input int vc, input int er, input int eg, input int eb);
      px_t e;
      @(posedge clock);
      #1;
      reset     = rst;
      hsv_valid = vld;
      h         = 8'(hh);
      s         = 8'(ss);
      v         = 8'(vv);
      hcount_in = 11'(hc);
      vcount_in = 10'(vc);
      if (rst) sb.delete();
      else if (vld) begin
         e.r = er; e.g = eg; e.b = eb; e.hc = hc; e.vc = vc;
         sb.push_back(e);
      end
   endtask

   task automatic drive_model(input logic vld, input int hh, input int ss, input int vv, input int hc, input int vc);
      px_t m;
      m = ref_px(hh, ss, vv, hc, vc);
      drive(1'b0, vld, hh, ss, vv, hc, vc, m.r, m.g, m.b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 2047), $urandom_range(0, 1023), 0, 0, 0);
   endtask

   // Expected valid timing: three-cycle delay, flushed by reset.
   always @(posedge clock) begin
      rst_q     <= reset;
      exp_vpipe <= reset ? 3'b000 : {exp_vpipe[1:0], hsv_valid};
      if (reset) armed <= 1'b1;
   end

   // Output monitor: valid timing, scoreboard pop, and hold/reset values every cycle.
   always @(negedge clock) begin : mon
      px_t e;
      if (armed) begin
         e = exp_out;
         if (rst_q) begin
            e.r = 0; e.g = 0; e.b = 0; e.hc = 0; e.vc = 0;
         end
         chk("valid", int'(rgb_valid), int'(exp_vpipe[2]));
         if (rgb_valid) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else e = sb.pop_front();
         end
         chk("r", int'(r), e.r);
         chk("g", int'(g), e.g);
         chk("b", int'(b), e.b);
         chk("hcount", int'(hcount_out), e.hc);
         chk("vcount", int'(vcount_out), e.vc);
`ifdef HSV2RGB_PACK444_EN
         chk("rgb444", int'(rgb444), ((e.r >> 4) << 8) | ((e.g >> 4) << 4) | (e.b >> 4));
`endif
         exp_out <= e;
      end
   end

   initial begin
      int hs[11];
      reset     = 1'b1;
      hsv_valid = 1'b0;
      h = '0; s = '0; v = '0;
      hcount_in = '0;
      vcount_in = '0;
      exp_vpipe = 3'b000;
      exp_out   = '{0, 0, 0, 0, 0};

      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

      // pure red on the first cycle out of reset, then hold
      drive(1'b0, 1'b1, 0, 255, 255, 5, 7, 255, 0, 0);
      idle(5);

      // hue points at sector edges, back to back
      drive(1'b0, 1'b1, 85, 255, 255, 10, 1, 3, 255, 0);
      drive(1'b0, 1'b1, 171, 255, 255, 11, 1, 0, 3, 255);
      idle(5);

      // sector boundaries through the reference model
      hs = '{42, 43, 85, 86, 128, 129, 171, 172, 214, 215, 255};
      foreach (hs[i]) drive_model(1'b1, hs[i], 200, 180, 100 + i, 2);
      idle(4);

      // grey sweep: all hues give (128,128,128)
      for (int i = 0; i < 256; i++) drive(1'b0, 1'b1, i, 0, 128, i, 300, 128, 128, 128);
      idle(4);

      // random stream with random gaps
      for (int i = 0; i < 400; i++)
         drive_model(($urandom_range(0, 3) != 0), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 2047), $urandom_range(0, 1023));
      idle(5);

      // reset while three pixels are in flight: none may emerge, outputs read zero
      drive(1'b0, 1'b1, 20, 255, 255, 50, 5, 255, 0, 0);
      drive(1'b0, 1'b1, 100, 255, 255, 51, 5, 0, 0, 0);
      drive(1'b1, 1'b1, 200, 255, 255, 52, 5, 0, 0, 0);
      idle(6);

      // stream resumes cleanly after reset
      drive_model(1'b1, 60, 90, 240, 7, 8);
      idle(5);

      chk("drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/hsv2rgb.md
HSV2RGB -- requirements
Module: hsv2rgb

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- h  in  8  hue, 0..255 maps to one full colour circle.
- s  in  8  saturation, 0..255.
- v  in  8  value, 0..255.
- hsv_valid  in  1  h/s/v/hcount_in/vcount_in are qualified this cycle.
- hcount_in  in  11  pixel column tag, travels with the pixel.
- vcount_in  in  10  pixel row tag, travels with the pixel.
- r  out  8  red.
- g  out  8  green.
- b  out  8  blue.
- rgb_valid  out  1  r/g/b/hcount_out/vcount_out are qualified this cycle.
- hcount_out  out  11  hcount_in delayed to align with r/g/b.
- vcount_out  out  10  vcount_in delayed to align with r/g/b.
- rgb444  out  12  only when HSV2RGB_PACK444_EN is defined; see REQ-017.
REQ-002 SHALL have no parameters; all widths are fixed as listed in REQ-001.

Function
REQ-003 SHALL be a fully pipelined, 3-stage converter with no backpressure, accepting one pixel per cycle.
REQ-004 SHALL assert rgb_valid exactly 3 cycles after the cycle in which hsv_valid was sampled high; valid SHALL propagate through stages regardless of data.
REQ-005 Stage 1 SHALL register:
- region = floor(h/43), range 0..5 (h=255 gives 5);
- rem = (h - region*43)*6, range 0..252, 8 bits;
- s, v, hcount_in, vcount_in.
REQ-006 Stage 2 SHALL register, using unsigned 16-bit products truncated by a right shift of 8:
- p = (v*(255-s))>>8;
- q = (v*(255-((s*rem)>>8)))>>8;
- t = (v*(255-((s*(255-rem))>>8)))>>8;
- plus v, region, an s==0 flag, and the tags.
REQ-007 Stage 3 SHALL select (r,g,b) by region:
- 0: (v,t,p)
- 1: (q,v,p)
- 2: (p,v,t)
- 3: (p,q,v)
- 4: (t,p,v)
- 5: (v,p,q)
REQ-008 When s==0, the output SHALL be (v,v,v) irrespective of h.
REQ-009 r, g, b, hcount_out and vcount_out SHALL update only on cycles in which stage-3 valid is high, and SHALL hold their last value otherwise.
REQ-010 Internal stage data registers MAY update every cycle; only the output registers are required to hold.
REQ-011 Back-to-back valid pixels SHALL produce back-to-back rgb_valid with no bubbles; a gap of N invalid cycles at the input SHALL appear as an identical N-cycle gap at the output.
REQ-012 All arithmetic SHALL be unsigned with no overflow: every intermediate fits 16 bits and every result fits 8 bits.

Reset
REQ-013 While reset is high, all stage valids and rgb_valid SHALL be 0, and r, g, b, hcount_out and vcount_out SHALL be 0 from the next edge.
REQ-014 Reset mid-stream SHALL discard all in-flight pixels; no rgb_valid pulse may emerge from data accepted before or during reset.
REQ-015 The first pixel accepted on the first cycle after reset deasserts SHALL appear with rgb_valid 3 cycles later.

Configuration
REQ-016 Macro HSV2RGB_PACK444_EN SHALL control the rgb444 port.
REQ-017 With HSV2RGB_PACK444_EN defined:
- output rgb444 = {r[7:4], g[7:4], b[7:4]}, registered on the same edge as r/g/b;
- follows the same hold and reset rules (reset value 12'h000), matching the camera 4:4:4 pixel layout.
REQ-018 Without HSV2RGB_PACK444_EN, the rgb444 port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-019 Red: h=0, s=255, v=255, valid for 1 cycle -> 3 cycles later rgb_valid=1 with (255,0,0); next cycle rgb_valid=0 and values held.
REQ-020 Hue points: h=85/s=255/v=255 -> (3,255,0); h=171/s=255/v=255 -> (0,3,255), checked against REQ-005..007 arithmetic.
REQ-021 Grey: s=0, v=128, h sweeps 0..255 on consecutive cycles -> 256 consecutive outputs of (128,128,128), hcount/vcount tags aligned.
REQ-022 Streaming: random h/s/v with a random hsv_valid pattern -> output valid pattern equals the input pattern delayed 3 cycles, and data matches the reference model.
REQ-023 Reset mid-stream: 3 valid pixels in flight, then reset for 1 cycle -> no rgb_valid emerges from those pixels and outputs read 0.
REQ-024 With HSV2RGB_PACK444_EN defined: input (h=0, s=255, v=255) -> rgb444 = 12'hF00.
